// File: rtl/axi3_pkg.sv
// Shared AXI3 constants and the burst-writer state type.
package axi3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [2:0] AXSIZE_4B   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi3_hp_writer_if.sv
// Write-only AXI3 channel bundle (AW, W, B) toward a Zynq HP slave port.
interface axi3_hp_writer_if;
  logic        m00_axi_awready;
  logic [31:0] m00_axi_awaddr;
  logic [3:0]  m00_axi_awlen;
  logic [2:0]  m00_axi_awsize;
  logic [1:0]  m00_axi_awburst;
  logic        m00_axi_awvalid;
  logic        m00_axi_wready;
  logic [31:0] m00_axi_wdata;
  logic [3:0]  m00_axi_wstrb;
  logic        m00_axi_wlast;
  logic        m00_axi_wvalid;
  logic        m00_axi_bvalid;
  logic [1:0]  m00_axi_bresp;
  logic        m00_axi_bready;

  modport master (
    input  m00_axi_awready, m00_axi_wready, m00_axi_bvalid, m00_axi_bresp,
    output m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
           m00_axi_awvalid, m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast,
           m00_axi_wvalid, m00_axi_bready
  );

  modport slave (
    output m00_axi_awready, m00_axi_wready, m00_axi_bvalid, m00_axi_bresp,
    input  m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
           m00_axi_awvalid, m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast,
           m00_axi_wvalid, m00_axi_bready
  );
endinterface

// File: rtl/axi3_hp_writer.sv
// Single-outstanding AXI3 INCR burst writer: drains BURST_SIZE words from a
// FIFO read port into DDR through a Zynq HP port, one burst per DMA_START.
module axi3_hp_writer
  import axi3_pkg::*;
#(
  parameter int unsigned BURST_SIZE = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [28:0]        DMA_WR_ADDR,
  input  logic               DMA_START,
  output logic               DMA_READY,
  input  logic [31:0]        DMA_WR_DATA,
  input  logic               DMA_WR_DATA_VALID,
  output logic               DMA_WR_DATA_READY,
  output logic               DMA_DONE,
  output logic               DMA_ERROR,
  axi3_hp_writer_if.master   m00_axi
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_SIZE - 1);

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic        bready_q, bready_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  beat_q, beat_d;

  logic wvalid, wlast, aw_hs, w_hs, b_hs;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      beat_q    <= beat_d;
    end
  end

  assign aw_hs = awvalid_q & m00_axi.m00_axi_awready;
  assign w_hs  = wvalid & m00_axi.m00_axi_wready;
  assign b_hs  = bready_q & m00_axi.m00_axi_bvalid;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    error_d   = error_q;
    beat_d    = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (DMA_START && ready_q) begin
          awaddr_d  = {DMA_WR_ADDR, 3'b000};
          awvalid_d = 1'b1;
          ready_d   = 1'b0;
          error_d   = 1'b0;
          beat_d    = '0;
          state_d   = ST_ADDR;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        // Counter parks on the last beat so it never exceeds BURST_SIZE-1.
        if (w_hs) begin
          if (wlast) begin
            bready_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      ST_RESP: begin
        // READY stays low through the DONE cycle; IDLE raises it one cycle later.
        if (b_hs) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          error_d  = (m00_axi.m00_axi_bresp == RESP_SLVERR) ||
                     (m00_axi.m00_axi_bresp == RESP_DECERR);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (state_q == ST_DATA) begin
      wvalid = DMA_WR_DATA_VALID;
      wlast  = (beat_q == LAST_BEAT);
    end
  end

  assign DMA_READY         = ready_q;
  assign DMA_DONE          = done_q;
  assign DMA_ERROR         = error_q;
  assign DMA_WR_DATA_READY = w_hs;

  assign m00_axi.m00_axi_awaddr  = awaddr_q;
  assign m00_axi.m00_axi_awlen   = LAST_BEAT;
  assign m00_axi.m00_axi_awsize  = AXSIZE_4B;
  assign m00_axi.m00_axi_awburst = BURST_INCR;
  assign m00_axi.m00_axi_awvalid = awvalid_q;
  assign m00_axi.m00_axi_wdata   = DMA_WR_DATA;
  assign m00_axi.m00_axi_wstrb   = 4'hF;
  assign m00_axi.m00_axi_wlast   = wlast;
  assign m00_axi.m00_axi_wvalid  = wvalid;
  assign m00_axi.m00_axi_bready  = bready_q;

endmodule
